// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Purpose:
//   Multi-channel push-button debouncer. Each raw button bit is brought into
//   the CLK domain by a two-flop synchronizer. It is accepted as a new level
//   only after it has differed from the current debounced level for CNT_MAX
//   consecutive cycles. A single matching cycle restarts the count, which
//   rejects glitches. Registered one-cycle pulses mark debounced presses and
//   releases. Channels never interact.
//
// Optional feature (macro BUTTON_DEBOUNCER_LONGPRESS_EN):
//   When the macro is defined, each channel also counts how long the
//   debounced level has been high. It emits a single o_LONG pulse LONG_MAX
//   cycles after o_PRESS. When the macro is undefined, o_LONG is tied low.
//   The port list is the same in both builds.
//
// Parameters:
//   N_CH     number of independent channels (>= 1)
//   CNT_MAX  stable cycles needed to accept a level change (>= 2)
//   CNT_W    debounce counter width, must hold CNT_MAX-1
//   LONG_MAX held cycles after press before the long-press pulse (>= 2)
//   LONG_W   long-press counter width, must hold LONG_MAX-1
//
// Ports:
//   CLK        in   single clock for all logic
//   i_RST_N    in   synchronous active-low reset
//   i_BTN      in   [N_CH] raw asynchronous button levels
//   o_BTN      out  [N_CH] debounced level (the state register itself)
//   o_PRESS    out  [N_CH] one-cycle pulse, first cycle o_BTN is 1
//   o_RELEASE  out  [N_CH] one-cycle pulse, first cycle o_BTN is 0 again
//   o_LONG     out  [N_CH] one-cycle long-press pulse
// -----------------------------------------------------------------------------
module button_debouncer #(
   parameter int N_CH     = 4,
   parameter int CNT_MAX  = 250000,
   parameter int CNT_W    = 18,
   parameter int LONG_MAX = 12500000,
   parameter int LONG_W   = 24
) (
   input  logic            CLK,
   input  logic            i_RST_N,
   input  logic [N_CH-1:0] i_BTN,
   output logic [N_CH-1:0] o_BTN,
   output logic [N_CH-1:0] o_PRESS,
   output logic [N_CH-1:0] o_RELEASE,
   output logic [N_CH-1:0] o_LONG
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

   logic [N_CH-1:0] sync_meta_r;
   logic [N_CH-1:0] sync_r;

   // Two-flop synchronizer; only sync_r is used by the channel logic.
   always_ff @(posedge CLK) begin
      if (!i_RST_N) begin
         sync_meta_r <= {N_CH{1'b0}};
         sync_r      <= {N_CH{1'b0}};
      end else begin
         sync_meta_r <= i_BTN;
         sync_r      <= sync_meta_r;
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic             state_r;
      logic             state_s;
      logic [CNT_W-1:0] cnt_r;
      logic [CNT_W-1:0] cnt_s;
      logic             press_r;
      logic             press_s;
      logic             release_r;
      logic             release_s;

      // Debounce next state: count mismatching cycles and accept the level on the last one.
      always_comb begin
         state_s   = state_r;
         cnt_s     = {CNT_W{1'b0}};
         press_s   = 1'b0;
         release_s = 1'b0;
         if (sync_r[k] == state_r) begin
            // Any agreeing cycle throws away the partial count.
            cnt_s = {CNT_W{1'b0}};
         end else if (cnt_r == CNT_LAST) begin
            state_s   = sync_r[k];
            cnt_s     = {CNT_W{1'b0}};
            press_s   = sync_r[k];
            release_s = ~sync_r[k];
         end else begin
            cnt_s = cnt_r + CNT_W'(1);
         end
      end

      // Debounce state, counter and edge-pulse registers.
      always_ff @(posedge CLK) begin
         if (!i_RST_N) begin
            state_r   <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            press_r   <= 1'b0;
            release_r <= 1'b0;
         end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            press_r   <= press_s;
            release_r <= release_s;
         end
      end

      assign o_BTN[k]     = state_r;
      assign o_PRESS[k]   = press_r;
      assign o_RELEASE[k] = release_r;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
      localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 1);

      logic [LONG_W-1:0] long_cnt_r;
      logic [LONG_W-1:0] long_cnt_s;
      logic              long_done_r;
      logic              long_done_s;
      logic              long_r;
      logic              long_s;

      // Long-press next state: saturating hold counter plus a fired flag so the
      // pulse happens once per press. It does not fire on a cycle that releases.
      always_comb begin
         long_cnt_s  = long_cnt_r;
         long_done_s = long_done_r;
         long_s      = 1'b0;
         if (!state_r) begin
            long_cnt_s  = {LONG_W{1'b0}};
            long_done_s = 1'b0;
         end else if (long_cnt_r != LONG_LAST) begin
            long_cnt_s = long_cnt_r + LONG_W'(1);
         end else if (!long_done_r && state_s) begin
            long_s      = 1'b1;
            long_done_s = 1'b1;
         end else begin
            long_cnt_s = long_cnt_r;
         end
      end

      // Long-press counter, fired flag and pulse registers.
      always_ff @(posedge CLK) begin
         if (!i_RST_N) begin
            long_cnt_r  <= {LONG_W{1'b0}};
            long_done_r <= 1'b0;
            long_r      <= 1'b0;
         end else begin
            long_cnt_r  <= long_cnt_s;
            long_done_r <= long_done_s;
            long_r      <= long_s;
         end
      end

      assign o_LONG[k] = long_r;
`else
      assign o_LONG[k] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Self-checking bench for button_debouncer with N_CH=2, CNT_MAX=4,
// LONG_MAX=10. A reference model derives every expected output from the
// history of raw samples. A level flips when the CNT_MAX synchronized samples
// before an edge all disagree with it, and no flip or reset has happened in
// the last CNT_MAX edges. The model is compared against the DUT after every
// edge. Directed scenarios also measure latencies and pulse counts.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

   localparam int N_CH     = 2;
   localparam int CNT_MAX  = 4;
   localparam int LONG_MAX = 10;
   localparam int MAXE     = 8192;
`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic            CLK;
   logic            i_RST_N;
   logic [N_CH-1:0] i_BTN;
   logic [N_CH-1:0] o_BTN;
   logic [N_CH-1:0] o_PRESS;
   logic [N_CH-1:0] o_RELEASE;
   logic [N_CH-1:0] o_LONG;

   button_debouncer #(
      .N_CH(N_CH), .CNT_MAX(CNT_MAX), .CNT_W(3), .LONG_MAX(LONG_MAX), .LONG_W(4)
   ) dut (
      .CLK(CLK), .i_RST_N(i_RST_N), .i_BTN(i_BTN), .o_BTN(o_BTN),
      .o_PRESS(o_PRESS), .o_RELEASE(o_RELEASE), .o_LONG(o_LONG)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int edge_no  = 0;

   // Reference model state.
   logic [N_CH-1:0] samp [0:MAXE-1];
   logic [N_CH-1:0] m_btn, m_press, m_rel, m_long;
   int              last_flip [N_CH];
   int              press_edge [N_CH];

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_no, obs, exp);
      end
   endtask

   task automatic model_edge(input logic rst_n_v, input logic [N_CH-1:0] btn_v);
      bit flip;
      m_press = '0; m_rel = '0; m_long = '0;
      if (!rst_n_v) begin
         samp[edge_no] = '0;
         m_btn = '0;
         for (int c = 0; c < N_CH; c++) last_flip[c] = edge_no;
      end else begin
         samp[edge_no] = btn_v;
         for (int c = 0; c < N_CH; c++) begin
            flip = (edge_no - last_flip[c]) >= CNT_MAX;
            for (int j = 2; j <= CNT_MAX + 1; j++)
               if (flip && samp[edge_no - j][c] == m_btn[c]) flip = 1'b0;
            if (flip) begin
               m_press[c]   = ~m_btn[c];
               m_rel[c]     = m_btn[c];
               m_btn[c]     = ~m_btn[c];
               last_flip[c] = edge_no;
               if (m_btn[c]) press_edge[c] = edge_no;
            end
            m_long[c] = LONG_EN && m_btn[c] && (edge_no - press_edge[c] == LONG_MAX);
         end
      end
   endtask

   task automatic tick(input logic rst_n_v, input logic [N_CH-1:0] btn_v);
      i_RST_N = rst_n_v;
      i_BTN   = btn_v;
      @(posedge CLK);
      edge_no++;
      model_edge(rst_n_v, btn_v);
      #1;
      for (int c = 0; c < N_CH; c++) begin
         check($sformatf("o_BTN[%0d]", c),     int'(o_BTN[c]),     int'(m_btn[c]));
         check($sformatf("o_PRESS[%0d]", c),   int'(o_PRESS[c]),   int'(m_press[c]));
         check($sformatf("o_RELEASE[%0d]", c), int'(o_RELEASE[c]), int'(m_rel[c]));
         check($sformatf("o_LONG[%0d]", c),    int'(o_LONG[c]),    int'(m_long[c]));
      end
   endtask

   // Holds btn until o_BTN[ch] reaches lvl (bounded), counting edges and pulses.
   task automatic wait_level(input logic [N_CH-1:0] btn, input int ch, input logic lvl,
                             output int n, output int presses, output int releases);
      n = 0; presses = 0; releases = 0;
      do begin
         tick(1'b1, btn);
         n++;
         presses  += int'(o_PRESS[ch]);
         releases += int'(o_RELEASE[ch]);
      end while (o_BTN[ch] !== lvl && n < 20);
   endtask

   initial begin
      int n, pr, rl, cnt, at, ch1_act;
      logic tog;
      logic [N_CH-1:0] rb;
      i_RST_N = 1'b0;
      i_BTN   = '0;
      m_btn   = '0;
      for (int c = 0; c < N_CH; c++) begin last_flip[c] = 0; press_edge[c] = -1000; end

      // Reset with random raw levels: all outputs must stay low.
      for (int i = 0; i < 4; i++) tick(1'b0, N_CH'($urandom_range(0, 3)));
      for (int i = 0; i < 8; i++) tick(1'b1, 2'b00);

      // Clean press on channel 0, then hold for the long-press window.
      wait_level(2'b01, 0, 1'b1, n, pr, rl);
      check("press_latency", n, 6);
      check("press_pulses", pr, 1);
      check("ch1_idle", int'(o_BTN[1]), 0);
      cnt = 0; at = -1;
      for (int i = 1; i <= 60; i++) begin
         tick(1'b1, 2'b01);
         if (o_LONG[0]) begin cnt++; at = i; end
      end
      check("long_count", cnt, LONG_EN ? 1 : 0);
      check("long_pos", at, LONG_EN ? LONG_MAX : -1);

      // Release.
      wait_level(2'b00, 0, 1'b0, n, pr, rl);
      check("release_latency", n, 6);
      check("release_pulses", rl, 1);
      check("release_no_press", pr, 0);

      // Bounce: high 3, low 1, then high held.
      pr = 0;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, (i < 3) ? 2'b01 : 2'b00);
         pr += int'(o_PRESS[0]);
      end
      check("bounce_no_press", pr, 0);
      wait_level(2'b01, 0, 1'b1, n, pr, rl);
      check("bounce_latency", n, 6);
      wait_level(2'b00, 0, 1'b0, n, pr, rl);
      for (int i = 0; i < 6; i++) tick(1'b1, 2'b00);

      // Reset mid-count (counter at CNT_MAX-1), raw still high afterwards.
      for (int i = 0; i < 5; i++) tick(1'b1, 2'b01);
      cnt = 0;
      for (int i = 0; i < 2; i++) begin
         tick(1'b0, 2'b01);
         cnt += int'(o_BTN[0]) + int'(o_PRESS[0]) + int'(o_RELEASE[0]) + int'(o_LONG[0]);
      end
      check("reset_quiet", cnt, 0);
      wait_level(2'b01, 0, 1'b1, n, pr, rl);
      check("reset_relatency", n, 6);

      // Reset while high clears silently.
      tick(1'b0, 2'b01);
      check("reset_high_rel", int'(o_RELEASE[0]), 0);
      for (int i = 0; i < 3; i++) tick(1'b1, 2'b00);
      for (int i = 0; i < 6; i++) tick(1'b1, 2'b00);

      // Independence: ch1 toggles each cycle while ch0 is pressed cleanly.
      n = 0; ch1_act = 0; tog = 1'b1;
      do begin
         tick(1'b1, {tog, 1'b1});
         tog = ~tog;
         n++;
         ch1_act += int'(o_BTN[1]) + int'(o_PRESS[1]) + int'(o_RELEASE[1]);
      end while (o_BTN[0] !== 1'b1 && n < 20);
      check("indep_latency", n, 6);
      check("indep_ch1", ch1_act, 0);

      // Random runs with occasional reset, all checked against the model.
      rb = '0;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < N_CH; c++)
            if ($urandom_range(0, 5) == 0) rb[c] = ~rb[c];
         tick(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels (>=1).
REQ-002 SHALL have parameter CNT_MAX, default 250000: stable-cycle count required to accept a level change (>=2).
REQ-003 SHALL have parameter CNT_W, default 18: debounce counter width; must hold CNT_MAX-1.
REQ-004 SHALL have parameter LONG_MAX, default 12500000: held cycles after press before the long-press pulse (>=2).
REQ-005 SHALL have parameter LONG_W, default 24: long-press counter width; must hold LONG_MAX-1.
REQ-006 SHALL have port CLK  input  1  single clock for all logic.
REQ-007 SHALL have port i_RST_N  input  1  reset, synchronous to CLK, active-low.
REQ-008 SHALL have port i_BTN  input  N_CH  raw asynchronous button levels, bit k = channel k.
REQ-009 SHALL have port o_BTN  output  N_CH  debounced level per channel.
REQ-010 SHALL have port o_PRESS  output  N_CH  one-cycle pulse on a debounced 0->1 change.
REQ-011 SHALL have port o_RELEASE  output  N_CH  one-cycle pulse on a debounced 1->0 change.
REQ-012 SHALL have port o_LONG  output  N_CH  one-cycle long-press pulse.

Function
REQ-013 SHALL pass each i_BTN bit through a 2-flop synchronizer; only the second flop output (sync) feeds channel logic.
REQ-014 SHALL give each channel its own sync, state, debounce counter, long counter and pulse registers, with no cross-channel interaction.
REQ-015 Debounce counter: when sync == state, count <= 0.
REQ-016 Debounce counter: when sync != state and count < CNT_MAX-1, count <= count+1.
REQ-017 Debounce counter: when sync != state and count == CNT_MAX-1, state <= sync and count <= 0.
REQ-018 A single cycle of sync == state during counting SHALL restart the count from 0 (glitch rejection).
REQ-019 Latency: a clean raw change sampled at edge 1 SHALL appear on o_BTN after edge 2+CNT_MAX.
REQ-020 o_BTN SHALL be the state register directly, with no added delay.
REQ-021 o_PRESS[k] SHALL be 1 for exactly the first cycle in which o_BTN[k] is 1.
REQ-022 o_RELEASE[k] SHALL be 1 for exactly the first cycle in which o_BTN[k] is 0 after being 1.
REQ-023 Both pulses SHALL be registered, not combinational from i_BTN.
REQ-024 A channel SHALL change state at most once per CNT_MAX cycles; o_PRESS and o_RELEASE of one channel SHALL never be high together.
REQ-025 Counter arithmetic SHALL be unsigned CNT_W bits; the debounce counter SHALL never exceed CNT_MAX-1 or wrap.

Reset
REQ-026 While i_RST_N is 0 at a CLK edge, all sync flops, state, counters and pulse registers SHALL clear to 0.
REQ-027 During reset, o_BTN, o_PRESS, o_RELEASE and o_LONG SHALL read 0.
REQ-028 Reset mid-count SHALL discard progress and SHALL NOT emit any pulse.
REQ-029 Reset asserted while a channel is high SHALL clear it silently, with no o_RELEASE.
REQ-030 Raw input held high through reset SHALL be re-debounced from zero: o_BTN rises 2+CNT_MAX edges after the first edge with i_RST_N=1.

Configuration
REQ-031 With macro BUTTON_DEBOUNCER_LONGPRESS_EN defined, each channel SHALL have an LONG_W-bit long counter.
REQ-032 Long counter: cleared while state=0; increments each cycle state=1; saturates at LONG_MAX-1.
REQ-033 o_LONG[k] SHALL pulse exactly one cycle, in the cycle LONG_MAX cycles after o_PRESS[k], and SHALL not repeat until release and a new press.
REQ-034 Release before LONG_MAX cycles SHALL produce no o_LONG.
REQ-035 Without BUTTON_DEBOUNCER_LONGPRESS_EN: no long counters, o_LONG tied to 0, port list unchanged.

Verification (N_CH=2, CNT_MAX=4, LONG_MAX=10)
REQ-036 Clean press: i_BTN[0] 0->1 before edge 1, held -> o_BTN[0]=1 after edge 6; o_PRESS[0] high for that one cycle only; channel 1 stays 0.
REQ-037 Bounce: i_BTN[0] high 3 cycles, low 1 cycle, then high held -> no o_PRESS during the bounce; o_BTN[0] rises 6 edges after the final rise.
REQ-038 Release: i_BTN[0] 1->0 held -> o_BTN[0]=0 6 edges later; single o_RELEASE[0] pulse; no o_PRESS.
REQ-039 Long press (macro on): hold channel 0 -> o_LONG[0] pulses once, 10 cycles after o_PRESS[0]; holding 50 more cycles gives no further pulse. Macro off: o_LONG stays 0.
REQ-040 Reset mid-count: i_RST_N=0 when count=3 -> all outputs 0, no pulses; with raw still high, o_BTN[0] rises 6 edges after reset release.
REQ-041 Independence: channel 0 pressed cleanly while channel 1 toggles every cycle -> channel 0 gives the REQ-036 timing; channel 1 stays 0 with no pulses.
